// File: rtl/serial_byte_deserializer_pkg.sv
// Shared definitions for the serial byte path (deserializer now, transmitter later).
package serial_byte_deserializer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

  // Ceiling log2, never below 1 so single-value counters still get a bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_byte_deserializer_timer.sv
// Modulo-CLKS_PER_BIT bit timer with mid-bit and end-of-bit pulses.
module bit_timer
  import serial_byte_deserializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_clear,
  output logic o_half,
  output logic o_wrap
);

  localparam int TW   = clog2_min1(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  logic [TW-1:0] r_count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (i_clear || o_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_half = (r_count == TW'(HALF - 1));
  assign o_wrap = (r_count == TW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/serial_byte_deserializer.sv
// Idle-high async-frame receiver: start bit, LSB-first data, stop bit; valid/error strobes.
module serial_byte_deserializer
  import serial_byte_deserializer_pkg::*;
#(
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Din,
  output logic [DATA_BITS-1:0] Dout,
  output logic                 Valid,
  output logic                 FrameErr,
  output logic                 Busy
);

  localparam int IW = clog2_min1(DATA_BITS);

  generate
    if (DATA_BITS < 1 || DATA_BITS > 16) begin : g_bad_data_bits
      $error("serial_byte_deserializer: DATA_BITS must be 1..16");
    end
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 255) begin : g_bad_clks
      $error("serial_byte_deserializer: CLKS_PER_BIT must be 2..255");
    end
  endgenerate

  state_t               r_state;
  state_t               w_state_next;
  logic [IW-1:0]        r_index;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_valid;
  logic                 r_ferr;
  logic [DATA_BITS-1:0] w_shift_in;
  logic                 w_half;
  logic                 w_wrap;
  logic                 w_timer_clear;
  logic                 w_shift_en;
  logic                 w_index_clear;
  logic                 w_index_inc;
  logic                 w_load;
  logic                 w_err;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_clear (w_timer_clear),
    .o_half  (w_half),
    .o_wrap  (w_wrap)
  );

  // New bits enter at the MSB so the first data bit ends up at the LSB.
  generate
    if (DATA_BITS == 1) begin : g_shift_one
      assign w_shift_in = Din;
    end else begin : g_shift_many
      assign w_shift_in = {Din, r_shift[DATA_BITS-1:1]};
    end
  endgenerate

  always_comb begin
    w_state_next  = r_state;
    w_timer_clear = 1'b0;
    w_shift_en    = 1'b0;
    w_index_clear = 1'b0;
    w_index_inc   = 1'b0;
    w_load        = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      IDLE: begin
        w_timer_clear = 1'b1;
        if (!Din) w_state_next = START;
      end
      START: begin
        if (w_half) begin
          if (!Din) begin
            w_state_next  = DATA;
            w_timer_clear = 1'b1;
            w_index_clear = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (w_wrap) begin
          w_shift_en = 1'b1;
          if (r_index == IW'(DATA_BITS - 1)) w_state_next = STOP;
          else                               w_index_inc  = 1'b1;
        end
      end
      STOP: begin
        if (w_wrap) begin
          if (Din) begin
            w_load       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_err        = 1'b1;
            w_state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        w_timer_clear = 1'b1;
        if (Din) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
      r_index <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_index_clear)    r_index <= '0;
      else if (w_index_inc) r_index <= r_index + 1'b1;
      if (w_shift_en) r_shift <= w_shift_in;
      if (w_load)     r_dout  <= r_shift;
      r_valid <= w_load;
      r_ferr  <= w_err;
    end
  end

  assign Dout     = r_dout;
  assign Valid    = r_valid;
  assign FrameErr = r_ferr;
  assign Busy     = (r_state != IDLE);

endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Directed bench for serial_byte_deserializer at default parameters (8 bits, 4 clocks/bit).
module tb_serial_byte_deserializer;

  logic       Clk;
  logic       Reset;
  logic       Din;
  logic [7:0] Dout;
  logic       Valid;
  logic       FrameErr;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  logic       v_hist [64];
  logic       f_hist [64];
  logic       b_hist [64];
  logic [7:0] d_hist [64];

  serial_byte_deserializer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Din      (Din),
    .Dout     (Dout),
    .Valid    (Valid),
    .FrameErr (FrameErr),
    .Busy     (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drive Din for one rising edge, then sample just after it.
  task automatic tick(input logic d);
    @(negedge Clk);
    Din = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  // Line level at edge e of a frame: start 0..3, data bit i at 4+4i..7+4i, stop 36..39.
  function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int e);
    if (e < 4)  return 1'b0;
    if (e < 36) return d[(e - 4) / 4];
    return stop;
  endfunction

  task automatic run_frame(input logic [7:0] d, input logic stop, input int tail, input logic tail_lvl);
    for (int e = 0; e < 40 + tail; e++) begin
      tick((e < 40) ? frame_bit(d, stop, e) : tail_lvl);
      v_hist[e] = Valid;
      f_hist[e] = FrameErr;
      b_hist[e] = Busy;
      d_hist[e] = Dout;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    Din   = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({Dout, Valid, FrameErr, Busy} !== 11'h000) begin
      errors++;
      $display("FAIL reset_state got dout=%h v=%b fe=%b busy=%b exp all zero", Dout, Valid, FrameErr, Busy);
    end
    Reset = 1'b0;
    idle(3);
  endtask

  task automatic test_single;
    idle(3);
    run_frame(8'hA5, 1'b1, 2, 1'b1);
    for (int e = 0; e < 42; e++) begin
      checks++;
      if (v_hist[e] !== (e == 38)) begin
        errors++;
        $display("FAIL single_valid edge=%0d got %b exp %b", e, v_hist[e], (e == 38));
      end
      checks++;
      if (f_hist[e] !== 1'b0) begin
        errors++;
        $display("FAIL single_ferr edge=%0d got %b exp 0", e, f_hist[e]);
      end
      checks++;
      if (b_hist[e] !== (e <= 37)) begin
        errors++;
        $display("FAIL single_busy edge=%0d got %b exp %b", e, b_hist[e], (e <= 37));
      end
    end
    checks++;
    if (d_hist[38] !== 8'hA5) begin
      errors++;
      $display("FAIL single_dout got %h exp a5", d_hist[38]);
    end
  endtask

  task automatic test_glitch;
    logic [7:0] prev;
    int strobes;
    idle(2);
    prev    = Dout;
    strobes = 0;
    tick(1'b0);
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_start got %b exp 1", Busy);
    end
    for (int e = 1; e < 10; e++) begin
      tick(1'b1);
      if (Valid || FrameErr) strobes++;
      if (e == 2) begin
        checks++;
        if (Busy !== 1'b0) begin
          errors++;
          $display("FAIL glitch_back_idle got busy=%b exp 0", Busy);
        end
      end
    end
    checks++;
    if (strobes !== 0) begin
      errors++;
      $display("FAIL glitch_strobes got %0d exp 0", strobes);
    end
    checks++;
    if (Dout !== prev) begin
      errors++;
      $display("FAIL glitch_dout got %h exp %h", Dout, prev);
    end
  endtask

  task automatic test_frame_err;
    logic [7:0] prev;
    int nf, nv;
    idle(2);
    prev = Dout;
    run_frame(8'h3C, 1'b0, 10, 1'b0);
    nf = 0;
    nv = 0;
    for (int e = 0; e < 50; e++) begin
      nf += int'(f_hist[e]);
      nv += int'(v_hist[e]);
    end
    checks++;
    if (f_hist[38] !== 1'b1 || nf != 1) begin
      errors++;
      $display("FAIL ferr_pulse got at38=%b count=%0d exp 1 and 1", f_hist[38], nf);
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL ferr_no_valid got %0d exp 0", nv);
    end
    checks++;
    if (Dout !== prev) begin
      errors++;
      $display("FAIL ferr_dout_kept got %h exp %h", Dout, prev);
    end
    checks++;
    if (b_hist[49] !== 1'b1) begin
      errors++;
      $display("FAIL ferr_wait_busy got %b exp 1", b_hist[49]);
    end
    tick(1'b1);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_no_retrigger got busy=%b exp 0", Busy);
    end
    idle(2);
    run_frame(8'h01, 1'b1, 2, 1'b1);
    nv = 0;
    for (int e = 0; e < 42; e++) nv += int'(v_hist[e]);
    checks++;
    if (v_hist[38] !== 1'b1 || nv != 1 || d_hist[38] !== 8'h01) begin
      errors++;
      $display("FAIL ferr_recover got v38=%b count=%0d dout=%h exp 1 1 01", v_hist[38], nv, d_hist[38]);
    end
  endtask

  task automatic test_reset_mid;
    int nv;
    idle(2);
    for (int e = 0; e < 18; e++) tick(frame_bit(8'h5A, 1'b1, e));
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if ({Dout, Valid, FrameErr, Busy} !== 11'h000) begin
      errors++;
      $display("FAIL reset_mid_clear got dout=%h v=%b fe=%b busy=%b exp all zero", Dout, Valid, FrameErr, Busy);
    end
    repeat (3) tick(1'b1);
    Reset = 1'b0;
    idle(2);
    run_frame(8'h81, 1'b1, 2, 1'b1);
    nv = 0;
    for (int e = 0; e < 42; e++) nv += int'(v_hist[e]);
    checks++;
    if (nv != 1 || d_hist[38] !== 8'h81) begin
      errors++;
      $display("FAIL reset_mid_next got count=%0d dout=%h exp 1 81", nv, d_hist[38]);
    end
  endtask

  task automatic test_reset_idle;
    Reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1);
      checks++;
      if ({Dout, Valid, FrameErr, Busy} !== 11'h000) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got dout=%h v=%b fe=%b busy=%b exp all zero", i, Dout, Valid, FrameErr, Busy);
      end
    end
    Reset = 1'b0;
    idle(2);
  endtask

  task automatic test_back_to_back;
    int p1, p2, n1, n2;
    logic [7:0] d1;
    p1 = -1; p2 = -1; n1 = 0; n2 = 0;
    idle(2);
    run_frame(8'hFF, 1'b1, 0, 1'b1);
    for (int e = 0; e < 40; e++) if (v_hist[e]) begin n1++; if (p1 < 0) p1 = e; end
    d1 = (p1 >= 0) ? d_hist[p1] : 8'hxx;
    run_frame(8'h00, 1'b1, 2, 1'b1);
    for (int e = 0; e < 42; e++) if (v_hist[e]) begin n2++; if (p2 < 0) p2 = e; end
    checks++;
    if (n1 != 1 || n2 != 1 || (40 + p2 - p1) != 40) begin
      errors++;
      $display("FAIL b2b_spacing got n1=%0d n2=%0d p1=%0d p2=%0d exp 1 1 gap 40", n1, n2, p1, p2);
    end
    checks++;
    if (d1 !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_first got %h exp ff", d1);
    end
    checks++;
    if (p2 < 0 || d_hist[p2] !== 8'h00) begin
      errors++;
      $display("FAIL b2b_second got %h exp 00", (p2 >= 0) ? d_hist[p2] : 8'hxx);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Din   = 1'b1;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_reset_idle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
